key_scan_arb: RTL and testbench

KEY_SCAN_ARB -- requirements
Module: key_scan_arb

---
 rtl/key_scan_arb.sv | 166 ++++++++++++++++
 tb/tb_key_scan_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_arb.sv
// key_scan_arb: round-robin key scanner sharing one debounce counter.
// Each raw key is synchronized, then a pointer walks the keys looking for
// a level that differs from the debounced copy. The first mismatch claims
// the shared counter. The new level is committed once it has held for
// DEB_DELAY+1 cycles. A commit produces a one-cycle press or release pulse,
// and each committed press inverts the key's ctrl bit.
// Optional feature: define KEY_LONG_PRESS_EN to add a long-press timer that
// pulses key_long[i] LONG_DELAY cycles after the newest committed press.
module key_scan_arb #(
  parameter int KEY_NUM    = 4,
  parameter int DEB_DELAY  = 20'h7_ffff,
  parameter int LONG_DELAY = 24'hff_ffff
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [KEY_NUM-1:0]         key,
  output logic [KEY_NUM-1:0]         key_stable,
  output logic [KEY_NUM-1:0]         key_press,
  output logic [KEY_NUM-1:0]         key_release,
  output logic [KEY_NUM-1:0]         ctrl,
  output logic [KEY_NUM-1:0]         key_long,
  output logic                       busy,
  output logic [$clog2(KEY_NUM)-1:0] cur_idx
);

  localparam int IDX_W = $clog2(KEY_NUM);
  localparam int CNT_W = $clog2(DEB_DELAY + 1);

  typedef enum logic {SCAN, DEB} state_t;

  state_t             state, state_nx;
  logic [KEY_NUM-1:0] key_meta, key_sync;
  logic [IDX_W-1:0]   ptr, ptr_nx, cur_idx_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [KEY_NUM-1:0] stable_nx, ctrl_nx, press_nx, release_nx;

  // Advance a key index, wrapping from the last key back to key 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(KEY_NUM - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Two-flop synchronizer. It resets to "released" so no phantom press appears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples pre-edge values and the two synchronizer stages stay distinct.
      key_meta <= key;
      key_sync <= key_meta;
    end
  end

  // Scan/debounce next-state logic and commit decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nx   = state;
    ptr_nx     = ptr;
    cur_idx_nx = cur_idx;
    cnt_nx     = cnt;
    stable_nx  = key_stable;
    ctrl_nx    = ctrl;
    press_nx   = '0;
    release_nx = '0;
    case (state)
      SCAN: begin
        if (key_sync[ptr] != key_stable[ptr]) begin
          state_nx   = DEB;
          cur_idx_nx = ptr;
          cnt_nx     = '0;
        end else begin
          ptr_nx = wrap_inc(ptr);
        end
      end
      DEB: begin
        if (key_sync[cur_idx] == key_stable[cur_idx]) begin
          // Bounce: drop the candidate silently and resume after this key.
          state_nx = SCAN;
          ptr_nx   = wrap_inc(cur_idx);
        end else if (cnt < CNT_W'(DEB_DELAY)) begin
          cnt_nx = cnt + CNT_W'(1);
        end else begin
          state_nx           = SCAN;
          ptr_nx             = wrap_inc(cur_idx);
          stable_nx[cur_idx] = key_sync[cur_idx];
          if (!key_sync[cur_idx]) begin
            press_nx[cur_idx] = 1'b1;
            ctrl_nx[cur_idx]  = ~ctrl[cur_idx];
          end else begin
            release_nx[cur_idx] = 1'b1;
          end
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  // State register. Reset here also discards any debounce in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SCAN;
      ptr         <= '0;
      cur_idx     <= '0;
      cnt         <= '0;
      key_stable  <= '1;
      ctrl        <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      cur_idx     <= cur_idx_nx;
      cnt         <= cnt_nx;
      key_stable  <= stable_nx;
      ctrl        <= ctrl_nx;
      key_press   <= press_nx;
      key_release <= release_nx;
    end
  end

  assign busy = (state == DEB);

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_DELAY + 1);

  logic             long_act;
  logic [IDX_W-1:0] long_idx;
  logic [LONG_W-1:0] long_cnt;

  // Single long-press timer. The newest committed press re-arms it, and a
  // release commit of the tracked key clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      long_act <= 1'b0;
      long_idx <= '0;
      long_cnt <= '0;
      key_long <= '0;
    end else begin
      key_long <= '0;
      if (press_nx != '0) begin
        long_act <= 1'b1;
        long_idx <= cur_idx;
        long_cnt <= '0;
      end else if (long_act) begin
        if (release_nx[long_idx]) begin
          long_act <= 1'b0;
        end else if (!key_stable[long_idx]) begin
          // The count is 0 in the press-pulse cycle, so the pulse registered
          // at LONG_DELAY-1 lands exactly LONG_DELAY cycles after the press.
          if (long_cnt == LONG_W'(LONG_DELAY - 1)) begin
            key_long[long_idx] <= 1'b1;
            long_act           <= 1'b0;
          end else begin
            long_cnt <= long_cnt + LONG_W'(1);
          end
        end
      end
    end
  end
`else
  assign key_long = '0;
`endif

endmodule

// File: tb/tb_key_scan_arb.sv
// tb_key_scan_arb: directed stimulus for key_scan_arb (KEY_NUM=4,
// DEB_DELAY=15, LONG_DELAY=100). Stimulus pushes the expected pulse events
// into a queue. A negedge monitor pops one event per observed pulse and
// compares kind, key, debounced levels, ctrl and debounce occupancy.
module tb_key_scan_arb;

  localparam int KN   = 4;
  localparam int DEB  = 15;
  localparam int LONG = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KN-1:0] key = '1;
  logic [KN-1:0] key_stable, key_press, key_release, ctrl, key_long;
  logic          busy;
  logic [1:0]    cur_idx;

  key_scan_arb #(.KEY_NUM(KN), .DEB_DELAY(DEB), .LONG_DELAY(LONG)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_stable(key_stable),
    .key_press(key_press), .key_release(key_release), .ctrl(ctrl),
    .key_long(key_long), .busy(busy), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            kind;   // 0 press, 1 release, 2 long
    int            idx;
    logic [KN-1:0] stable;
    logic [KN-1:0] ctrl;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cycle = 0;
  int  busy_run = 0;
  int  press_cyc[KN];
  logic [KN-1:0] ctrl_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int idx, input logic [KN-1:0] st);
    ev_t e;
    e.kind = kind; e.idx = idx; e.stable = st; e.ctrl = ctrl_m;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [KN-1:0] v);
    @(posedge clk);
    #1 key = v;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_stable"}, key_stable, 4'hF);
    check({name, "_ctrl"}, ctrl, 4'h0);
    check({name, "_pulses"}, {key_press, key_release, key_long}, 12'h000);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_cur_idx"}, cur_idx, 2'd0);
  endtask

  // Monitor: consume one expected event per pulse bit seen.
  always @(negedge clk) begin
    logic [KN-1:0] pr;
    ev_t e;
    int kind;
    cycle++;
    pr = key_press | key_release;
    if (pr != '0) begin
      check("pulse_onehot", $countones(pr), 1);
      for (int i = 0; i < KN; i++) begin
        if (pr[i]) begin
          kind = key_press[i] ? 0 : 1;
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", pr, 0);
          end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_idx", i, e.idx);
            check("ev_stable", key_stable, e.stable);
            check("ev_ctrl", ctrl, e.ctrl);
            check("deb_cycles", busy_run, DEB + 1);
            if (kind == 0) press_cyc[i] = cycle;
          end
        end
      end
    end
    if (key_long != '0) begin
      for (int i = 0; i < KN; i++) begin
        if (key_long[i]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_long", key_long, 0);
          end else begin
            e = exp_q.pop_front();
            check("long_kind", 2, e.kind);
            check("long_idx", i, e.idx);
            check("long_delay", cycle - press_cyc[i], LONG);
          end
        end
      end
    end
    if (busy === 1'b1) busy_run++;
    else busy_run = 0;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_hi;
    // Reset, then idle with all keys released.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    busy_hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hi++;
    end
    check("idle_busy", busy_hi, 0);
    check("idle_stable", key_stable, 4'hF);

    // Key 2 press, held long enough for a long press, then released.
    ctrl_m = 4'h4;
    push(0, 2, 4'hB);
`ifdef KEY_LONG_PRESS_EN
    push(2, 2, 4'hB);
`endif
    drive(4'hB);
    repeat (150) @(posedge clk);
    push(1, 2, 4'hF);
    drive(4'hF);
    drain("key2_drain");
    check("key2_ctrl", ctrl, 4'h4);
    check("key2_stable", key_stable, 4'hF);

    // Key 1 bounce: too short to commit.
    drive(4'hD);
    repeat (7) @(posedge clk);
    drive(4'hF);
    repeat (30) @(negedge clk);
    check("bounce_stable", key_stable, 4'hF);
    check("bounce_ctrl", ctrl, 4'h4);
    check("bounce_busy", busy, 1'b0);

    // Keys 0 and 3 together. After reset the pointer reaches key 0 first.
    @(posedge clk);
    #1 rst_n = 1'b0;
    ctrl_m = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset2");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    ctrl_m = 4'h1;
    push(0, 0, 4'hE);
    ctrl_m = 4'h9;
    push(0, 3, 4'h6);
    #1 key = 4'h6;
    drain("dual_press_drain");
    push(1, 0, 4'h7);
    drive(4'h7);
    drain("rel0_drain");
    push(1, 3, 4'hF);
    drive(4'hF);
    drain("rel3_drain");
    check("dual_ctrl", ctrl, 4'h9);

    // Key 1 press interrupted by reset at cnt=10, then a fresh debounce.
    drive(4'hD);
    for (int i = 0; i < 40 && busy !== 1'b1; i++) @(negedge clk);
    check("mid_deb_entered", busy, 1'b1);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    ctrl_m = 4'h0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_deb_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    ctrl_m = 4'h2;
    push(0, 1, 4'hD);
    drain("post_reset_press");
    push(1, 1, 4'hF);
    drive(4'hF);
    drain("post_reset_release");
    check("final_ctrl", ctrl, 4'h2);
    check("final_stable", key_stable, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
